// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC core: ISA opcodes, sequencer state
// encoding and the bundle of registered sequencer control outputs.
package cpu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_S0   = 4'd1,
        ST_S1   = 4'd2,
        ST_S2   = 4'd3,
        ST_S3   = 4'd4,
        ST_S4   = 4'd5,
        ST_S5   = 4'd6,
        ST_S6   = 4'd7,
        ST_S7   = 4'd8,
        ST_HALT = 4'd9
    } seq_state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
        logic busy;
    } seq_out_t;

    // True for the eight states of an instruction micro-sequence.
    function automatic logic in_sequence(input seq_state_t s);
        return (s inside {ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7});
    endfunction

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode classifier: splits an opcode into the instruction
// classes the sequencer cares about.
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opc,
    output logic                is_alu,
    output logic                is_sto,
    output logic                is_jmp,
    output logic                is_skz,
    output logic                is_hlt
);

    // LDA counts as ALU: it reads an operand and loads the accumulator.
    always_comb begin
        is_alu = 1'b0;
        is_sto = 1'b0;
        is_jmp = 1'b0;
        is_skz = 1'b0;
        is_hlt = 1'b0;
        case (opc)
            OP_HLT:                         is_hlt = 1'b1;
            OP_SKZ:                         is_skz = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: is_alu = 1'b1;
            OP_STO:                         is_sto = 1'b1;
            OP_JMP:                         is_jmp = 1'b1;
            default:                        is_hlt = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: one 8-state micro-sequence per instruction,
// started by rising edges of fetch, parked in HALT after HLT until reset.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt,
    output logic             busy
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic             fetch_d;
    logic             frise;
    logic [OPC_W-1:0] opc_q;
    logic             skip_q;
    seq_out_t         out_q;
    seq_out_t         out_nxt;

    logic is_alu;
    logic is_sto;
    logic is_jmp;
    logic is_skz;
    logic is_hlt;

    assign frise = fetch & ~fetch_d;

    cpu_op_decode u_decode (
        .opc    (opc_q),
        .is_alu (is_alu),
        .is_sto (is_sto),
        .is_jmp (is_jmp),
        .is_skz (is_skz),
        .is_hlt (is_hlt)
    );

    // A started sequence always runs to S7; frise only matters in IDLE and S7.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (frise) state_nxt = ST_S0;
            ST_S0:   state_nxt = ST_S1;
            ST_S1:   state_nxt = ST_S2;
            ST_S2:   state_nxt = ST_S3;
            ST_S3:   state_nxt = is_hlt ? ST_HALT : ST_S4;
            ST_S4:   state_nxt = ST_S5;
            ST_S5:   state_nxt = ST_S6;
            ST_S6:   state_nxt = ST_S7;
            ST_S7:   state_nxt = frise ? ST_S0 : ST_IDLE;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered. Entering S3 the opcode
    // is only just being latched, so the live bus is used; entering S5 the
    // same holds for zero, which is why S5's skip uses zero directly.
    always_comb begin
        out_nxt = '0;
        case (state_nxt)
            ST_S0: begin
                out_nxt.rd      = 1'b1;
                out_nxt.load_ir = 1'b1;
            end
            ST_S1: begin
                out_nxt.rd      = 1'b1;
                out_nxt.load_ir = 1'b1;
                out_nxt.inc_pc  = 1'b1;
            end
            ST_S3: out_nxt.inc_pc = (opcode != OP_HLT);
            ST_S4: begin
                out_nxt.rd          = is_alu;
                out_nxt.datactl_ena = is_sto;
                out_nxt.load_pc     = is_jmp;
            end
            ST_S5: begin
                out_nxt.rd          = is_alu;
                out_nxt.load_acc    = is_alu;
                out_nxt.datactl_ena = is_sto;
                out_nxt.wr          = is_sto;
                out_nxt.load_pc     = is_jmp;
                out_nxt.inc_pc      = is_skz & zero;
            end
            ST_S6: begin
                out_nxt.datactl_ena = is_sto;
                out_nxt.inc_pc      = is_skz & skip_q;
            end
            ST_HALT: out_nxt.halt = 1'b1;
            default: out_nxt = '0;
        endcase
        out_nxt.busy = in_sequence(state_nxt);
    end

    // State, edge detector, opcode/skip latches and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            fetch_d <= 1'b0;
            opc_q   <= '0;
            skip_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state   <= state_nxt;
            fetch_d <= fetch;
            out_q   <= out_nxt;
            if (state == ST_S2) opc_q <= opcode;
            if (state == ST_S4 && is_skz) skip_q <= zero;
        end
    end

    assign rd          = out_q.rd;
    assign wr          = out_q.wr;
    assign load_ir     = out_q.load_ir;
    assign inc_pc      = out_q.inc_pc;
    assign load_pc     = out_q.load_pc;
    assign load_acc    = out_q.load_acc;
    assign datactl_ena = out_q.datactl_ena;
    assign halt        = out_q.halt;
    assign busy        = out_q.busy;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of per-instruction output
// masks, hand-written corner sequences, then random traffic against a model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    typedef struct packed {
        logic rd;
        logic wr;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
        logic busy;
    } outs_t;

    // Bit i of each mask is the output value while in S<i>.
    typedef struct {
        logic [2:0] op;
        logic       zero;
        logic [7:0] rd;
        logic [7:0] wr;
        logic [7:0] ir;
        logic [7:0] inc;
        logic [7:0] pc;
        logic [7:0] acc;
        logic [7:0] dc;
    } vec_t;

    localparam int MODE_IDLE = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch;
    logic [2:0] opcode;
    logic       zero;
    logic       rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, busy;

    int vectors = 0;
    int errors  = 0;

    int         m_mode = MODE_IDLE;
    int         m_step = 0;
    logic [2:0] m_op   = 3'b000;
    logic       m_skip = 1'b0;
    logic       m_fd   = 1'b0;
    logic       m_frise;
    outs_t      m_exp  = '0;

    vec_t table_v[8];

    cpu_sequencer #(.OPC_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .opcode      (opcode),
        .zero        (zero),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs for step s of an instruction, from per-class masks.
    function automatic outs_t class_out(input logic [2:0] op, input logic skip, input int s);
        logic [7:0] rdm, wrm, irm, incm, pcm, accm, dcm;
        outs_t o;
        rdm = 8'h03; wrm = 8'h00; irm = 8'h03; incm = 8'h0A;
        pcm = 8'h00; accm = 8'h00; dcm = 8'h00;
        case (op)
            OP_HLT: incm = 8'h02;
            OP_SKZ: if (skip) incm = 8'h6A;
            OP_STO: begin wrm = 8'h20; dcm = 8'h70; end
            OP_JMP: pcm = 8'h30;
            default: begin rdm = 8'h33; accm = 8'h20; end
        endcase
        o = '{rd: rdm[s], wr: wrm[s], load_ir: irm[s], inc_pc: incm[s], load_pc: pcm[s],
              load_acc: accm[s], datactl_ena: dcm[s], halt: 1'b0, busy: 1'b1};
        return o;
    endfunction

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_step();
        if (reset) begin
            m_mode = MODE_IDLE; m_step = 0; m_op = 3'b000; m_skip = 1'b0; m_fd = 1'b0;
        end else begin
            m_frise = fetch && !m_fd;
            m_fd    = fetch;
            case (m_mode)
                MODE_IDLE: if (m_frise) begin m_mode = MODE_RUN; m_step = 0; end
                MODE_RUN: begin
                    if (m_step == 7) begin
                        if (m_frise) m_step = 0;
                        else m_mode = MODE_IDLE;
                    end else if (m_step == 3 && m_op == OP_HLT) begin
                        m_mode = MODE_HALT;
                    end else begin
                        if (m_step == 2) m_op = opcode;
                        if (m_step == 4 && m_op == OP_SKZ) m_skip = zero;
                        m_step = m_step + 1;
                    end
                end
                default: m_mode = MODE_HALT;
            endcase
        end
        if (m_mode == MODE_IDLE) m_exp = '0;
        else if (m_mode == MODE_HALT) m_exp = '{halt: 1'b1, default: 1'b0};
        else m_exp = class_out(m_op, m_skip, m_step);
    endtask

    // Drive one cycle of inputs, update the model, and land 1 ns past the edge.
    task automatic applyStimulus(input logic r, input logic f, input logic [2:0] op, input logic z);
        reset  = r;
        fetch  = f;
        opcode = op;
        zero   = z;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t expv);
        outs_t act;
        act = {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, busy};
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (rd wr ir inc pc acc dc halt busy)",
                     name, act, expv);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    initial begin
        outs_t e;
        int    ph;
        int    halted;
        logic  f;
        logic  r;
        logic [2:0] op;

        table_v[0] = '{OP_ADD, 1'b0, 8'h33, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h20, 8'h00};
        table_v[1] = '{OP_AND, 1'b1, 8'h33, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h20, 8'h00};
        table_v[2] = '{OP_XOR, 1'b0, 8'h33, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h20, 8'h00};
        table_v[3] = '{OP_LDA, 1'b1, 8'h33, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h20, 8'h00};
        table_v[4] = '{OP_STO, 1'b0, 8'h03, 8'h20, 8'h03, 8'h0A, 8'h00, 8'h00, 8'h70};
        table_v[5] = '{OP_JMP, 1'b1, 8'h03, 8'h00, 8'h03, 8'h0A, 8'h30, 8'h00, 8'h00};
        table_v[6] = '{OP_SKZ, 1'b1, 8'h03, 8'h00, 8'h03, 8'h6A, 8'h00, 8'h00, 8'h00};
        table_v[7] = '{OP_SKZ, 1'b0, 8'h03, 8'h00, 8'h03, 8'h0A, 8'h00, 8'h00, 8'h00};

        // Table-driven: one instruction per entry with 4-high/4-low fetch.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, table_v[i].op, table_v[i].zero);
            checkOutput($sformatf("reset_%0d", i), '0);
            for (int s = 0; s < 8; s++) begin
                applyStimulus(1'b0, s < 4, table_v[i].op, table_v[i].zero);
                e = '{rd: table_v[i].rd[s], wr: table_v[i].wr[s], load_ir: table_v[i].ir[s],
                      inc_pc: table_v[i].inc[s], load_pc: table_v[i].pc[s],
                      load_acc: table_v[i].acc[s], datactl_ena: table_v[i].dc[s],
                      halt: 1'b0, busy: 1'b1};
                checkOutput($sformatf("tbl%0d_op%0d_s%0d", i, table_v[i].op, s), e);
            end
        end

        // Back-to-back JMPs: busy never drops across S7 -> S0.
        applyStimulus(1'b1, 1'b0, OP_JMP, 1'b0);
        for (int c = 0; c < 24; c++) begin
            applyStimulus(1'b0, (c % 8) < 4, OP_JMP, 1'b0);
            checkOutput($sformatf("b2b_c%0d", c), m_exp);
            checkBit($sformatf("b2b_busy_c%0d", c), busy, 1'b1);
        end

        // HLT: halt from the cycle after S3, immune to fetch, cleared by reset.
        applyStimulus(1'b1, 1'b0, OP_HLT, 1'b0);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, (c % 8) < 4, OP_HLT, 1'b0);
            checkOutput($sformatf("hlt_c%0d", c), m_exp);
            if (c >= 4) checkBit($sformatf("hlt_halt_c%0d", c), halt, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, OP_LDA, 1'b0);
        checkOutput("hlt_reset", '0);
        applyStimulus(1'b0, 1'b0, OP_LDA, 1'b0);
        checkOutput("hlt_idle", '0);
        applyStimulus(1'b0, 1'b1, OP_LDA, 1'b0);
        checkOutput("hlt_restart", '{rd: 1'b1, load_ir: 1'b1, busy: 1'b1, default: 1'b0});

        // Reset while in S4 of ADD.
        applyStimulus(1'b1, 1'b0, OP_ADD, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, c < 4, OP_ADD, 1'b0);
            checkOutput($sformatf("rst_s4_c%0d", c), m_exp);
        end
        applyStimulus(1'b1, 1'b0, OP_ADD, 1'b0);
        checkOutput("rst_in_s4", '0);
        applyStimulus(1'b0, 1'b0, OP_ADD, 1'b0);
        checkOutput("rst_s4_after", '0);

        // A fetch rise sampled in S2 must not restart the sequence.
        applyStimulus(1'b1, 1'b0, OP_LDA, 1'b0);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b0, (c == 0) || (c == 3), OP_LDA, 1'b0);
            checkOutput($sformatf("s2rise_c%0d", c), m_exp);
        end
        checkOutput("s2rise_idle", '0);

        // Random traffic: mostly regular fetch with jitter, random ops and resets.
        applyStimulus(1'b1, 1'b0, OP_ADD, 1'b0);
        ph = 0;
        halted = 0;
        for (int n = 0; n < 3000; n++) begin
            f = (ph % 8) < 4;
            if ($urandom_range(0, 15) == 0) f = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) ph = ph + int'($urandom_range(1, 7));
            ph = ph + 1;
            op = ($urandom_range(0, 9) == 0) ? OP_HLT : 3'($urandom_range(1, 7));
            r  = ($urandom_range(0, 299) == 0) || (halted > 12);
            applyStimulus(r, f, op, 1'($urandom_range(0, 1)));
            checkOutput($sformatf("rand_%0d", n), m_exp);
            halted = (m_mode == MODE_HALT) ? halted + 1 : 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction-cycle controller for the 8-bit RISC CPU core. It runs one 8-state micro-sequence per instruction, aligned to rising edges of `fetch` from the phase generator. It decodes the 3-bit opcode and drives the PC, IR, accumulator and bus-control enables. It holds the core in a halted state after `HLT` until reset.

## Interface
- `OPC_W`, 3: opcode width. Fixed by the ISA; other values are unsupported.

- `clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `fetch`  in  1  instruction-phase strobe from phase generator (high 4 of every 8 cycles)
- `opcode`  in  OPC_W  IR[15:13]; valid from S2 onward
- `zero`  in  1  accumulator-zero flag
- `rd`  out  1  memory read enable
- `wr`  out  1  memory write enable
- `load_ir`  out  1  load instruction-register byte
- `inc_pc`  out  1  increment PC by one byte
- `load_pc`  out  1  load PC from IR address field
- `load_acc`  out  1  load accumulator from ALU result
- `datactl_ena`  out  1  drive accumulator onto data bus
- `halt`  out  1  core halted
- `busy`  out  1  state is in S0..S7

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- Opcode classes: ALU = ADD, AND, XOR, LDA.
- States: IDLE, S0–S7, HALT.
- Start condition `frise` = `fetch & ~fetch_d`, where `fetch_d` is `fetch` registered once.
- Transitions:
  - IDLE → S0 on `frise`.
  - S0 → S1 → S2 → S3 unconditionally.
  - S3 → HALT if opcode is HLT, else → S4.
  - S4 → S5 → S6 → S7 unconditionally.
  - S7 → S0 on `frise`, else → IDLE.
  - HALT → HALT; exits only by reset.
- `frise` is ignored in S0–S6. The sequence always completes once started, even if `fetch` drops.
- Opcode is latched into `opc_q` on the S2→S3 edge. `zero` is latched into `skip_q` on the S4→S5 edge, and only for SKZ.
- Outputs are registered and take the values for the state being entered. Every output not listed for a state is 0.
  - S0: `rd`, `load_ir`.
  - S1: `rd`, `load_ir`, `inc_pc`.
  - S2: none.
  - S3: `inc_pc`, except HLT.
  - HALT: `halt` only.
  - S4:
    - ALU: `rd`.
    - STO: `datactl_ena`.
    - JMP: `load_pc`.
  - S5:
    - ALU: `rd`, `load_acc`.
    - STO: `datactl_ena`, `wr`.
    - JMP: `load_pc`.
    - SKZ with `skip_q`=1: `inc_pc`.
  - S6:
    - STO: `datactl_ena`.
    - SKZ with `skip_q`=1: `inc_pc`.
  - S7: none.
- `wr` and `rd` are never high together.
- `busy` is 1 in S0–S7.

## Timing
- Reset: state IDLE; `fetch_d`, `opc_q`, `skip_q` and every output are 0.
- Reset overrides all other events, including mid-sequence and in HALT. The cycle after a reset edge always shows IDLE with all outputs 0.
- Start latency: `frise` is sampled at edge k; S0 outputs are visible after edge k.
- One instruction takes 8 cycles (S0–S7). PC advances +2 per instruction, or +4 for a taken SKZ.
- Back-to-back: with an 8-cycle `fetch` period, `frise` coincides with S7. The next S0 follows S7 directly, with no IDLE gap.
- `halt` rises on the edge entering S3→HALT (one cycle after S3 for HLT) and stays high.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams;
  - state encoding `seq_state_t` (10 states, one-hot or binary at implementer's choice, 4-bit minimum).
- Optional sub-module `cpu_op_decode`: combinational opcode → class flags (`is_alu`, `is_sto`, `is_jmp`, `is_skz`, `is_hlt`).
- Main FSM, latches and output registers live in `cpu_sequencer`.

## Test plan
- Reset, then `fetch` toggling 4 high / 4 low with opcode LDA: `rd`,`load_ir` high S0–S1; `inc_pc` in S1 and S3; `rd` in S4–S5; `load_acc` only in S5; `wr` never high.
- Opcode STO: `datactl_ena` high S4–S6; `wr` high only in S5; `rd` low S4–S7.
- Opcode SKZ with `zero`=1 at S4→S5: `inc_pc` high in S1, S3, S5, S6 (4 pulses). With `zero`=0: 2 pulses only.
- Opcode JMP: `load_pc` high in S4–S5; no `inc_pc` after S3. Continuous fetch: S7 goes directly to S0 with `busy` never dropping.
- Opcode HLT: `halt`=1 from the cycle after S3 onward; no further `rd`/`inc_pc` despite `fetch` toggling. Assert `reset`: all outputs 0 next cycle, then restart on next `frise`.
- `reset` asserted in S4 of ADD: next cycle state IDLE, `rd`=`load_acc`=0. A `frise` during S2 is ignored: no second S0 until after S7.
